// File: rtl/delay_line_arbiter.sv
// Round-robin arbiter sharing one two-phase self-timed delay line among clocked requesters.
// Define DELAY_ARB_TIMEOUT_EN to add the WAIT timeout and the ERR state.
module delay_line_arbiter #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TIMEOUT     = 200,
    localparam int unsigned IdW        = $clog2(NREQ)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NREQ-1:0]  req_i,
    output logic [NREQ-1:0]  ack_o,
    output logic [IdW-1:0]   grant_id_o,
    output logic             busy_o,
    output logic             dl_in_r_o,
    input  logic             dl_out_r_i,
    output logic [CNT_W-1:0] lat_cnt_o,
    output logic             lat_valid_o,
    output logic             err_o
);

    if (NREQ < 2 || NREQ > 8 || SYNC_STAGES < 2 || TIMEOUT >= (2 ** CNT_W) - 1) begin : g_bad_cfg
        $error("delay_line_arbiter: illegal parameter combination");
    end

`ifdef DELAY_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {StIdle, StWait, StAck, StErr} state_e;
    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
    logic err_q, err_d;
`else
    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;
`endif

    state_e           state_q, state_d;
    logic [IdW-1:0]   grant_q, grant_d;
    logic [IdW-1:0]   last_q, last_d;
    logic             dl_in_q, dl_in_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lat_q, lat_d;
    logic             lat_valid_q, lat_valid_d;
    logic [NREQ-1:0]  ack_q, ack_d;

    // sync_q[SYNC_STAGES] is a history copy of the last synchronizer stage for edge detection.
    logic [SYNC_STAGES:0] sync_q;
    logic                 ret_edge;
    logic [IdW-1:0]       winner;
    logic [NREQ-1:0]      grant_oh;
    int unsigned          idx;
    logic                 found;

    assign ret_edge = sync_q[SYNC_STAGES] ^ sync_q[SYNC_STAGES-1];
    assign grant_oh = {{(NREQ-1){1'b0}}, 1'b1} << grant_q;

    // First requester at or after last_q+1, wrapping modulo NREQ.
    always_comb begin
        winner = last_q;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = (32'(last_q) + i) % NREQ;
            if (!found && req_i[IdW'(idx)]) begin
                winner = IdW'(idx);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        dl_in_d     = dl_in_q;
        cnt_d       = cnt_q;
        lat_d       = lat_q;
        lat_valid_d = 1'b0;
        ack_d       = ack_q;
`ifdef DELAY_ARB_TIMEOUT_EN
        err_d       = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (|req_i) begin
                    grant_d = winner;
                    dl_in_d = ~dl_in_q;
                    cnt_d   = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (ret_edge) begin
                    lat_d       = cnt_q;
                    lat_valid_d = 1'b1;
                    ack_d       = grant_oh;
                    state_d     = StAck;
`ifdef DELAY_ARB_TIMEOUT_EN
                end else if (cnt_q == TimeoutVal) begin
                    lat_d   = TimeoutVal;
                    err_d   = 1'b1;
                    ack_d   = grant_oh;
                    state_d = StErr;
`endif
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef DELAY_ARB_TIMEOUT_EN
            StAck, StErr: begin
`else
            StAck: begin
`endif
                if (!req_i[grant_q]) begin
                    ack_d   = '0;
                    last_d  = grant_q;
                    state_d = StIdle;
`ifdef DELAY_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            last_q      <= IdW'(NREQ - 1);
            dl_in_q     <= 1'b0;
            cnt_q       <= '0;
            lat_q       <= '0;
            lat_valid_q <= 1'b0;
            ack_q       <= '0;
            sync_q      <= '0;
`ifdef DELAY_ARB_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            dl_in_q     <= dl_in_d;
            cnt_q       <= cnt_d;
            lat_q       <= lat_d;
            lat_valid_q <= lat_valid_d;
            ack_q       <= ack_d;
            sync_q      <= {sync_q[SYNC_STAGES-1:0], dl_out_r_i};
`ifdef DELAY_ARB_TIMEOUT_EN
            err_q       <= err_d;
`endif
        end
    end

    assign ack_o       = ack_q;
    assign grant_id_o  = grant_q;
    assign busy_o      = (state_q != StIdle);
    assign dl_in_r_o   = dl_in_q;
    assign lat_cnt_o   = lat_q;
    assign lat_valid_o = lat_valid_q;
`ifdef DELAY_ARB_TIMEOUT_EN
    assign err_o       = err_q;
`else
    assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_delay_line_arbiter.sv
// Randomized bench for delay_line_arbiter: a cycle-counting delay-line model plus a
// round-robin/latency reference; timeout cases run when DELAY_ARB_TIMEOUT_EN is defined.
module tb_delay_line_arbiter;
    localparam int unsigned NREQ    = 4;
    localparam int unsigned SYNC    = 2;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned TIMEOUT = 20;

    logic             clk;
    logic             rst_n;
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  ack;
    logic [1:0]       grant_id;
    logic             busy;
    logic             dl_in;
    logic             dl_out;
    logic [CNT_W-1:0] lat_cnt;
    logic             lat_valid;
    logic             err;

    int n_checks = 0;
    int n_errors = 0;

    delay_line_arbiter #(
        .NREQ        (NREQ),
        .SYNC_STAGES (SYNC),
        .CNT_W       (CNT_W),
        .TIMEOUT     (TIMEOUT)
    ) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .ack_o       (ack),
        .grant_id_o  (grant_id),
        .busy_o      (busy),
        .dl_in_r_o   (dl_in),
        .dl_out_r_i  (dl_out),
        .lat_cnt_o   (lat_cnt),
        .lat_valid_o (lat_valid),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Delay line: returns each launch dly_cycles clock edges later; shares the reset net.
    int   dly_cycles = 4;
    bit   line_en    = 1'b1;
    int   stray_cnt  = 0;
    int   stray_seen;
    logic prev_in;
    bit   pend;
    int   cnt_rem;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_out     <= 1'b0;
            prev_in    <= 1'b0;
            pend       <= 1'b0;
            cnt_rem    <= 0;
            stray_seen <= stray_cnt;
        end else if (stray_seen != stray_cnt) begin
            stray_seen <= stray_cnt;
            dl_out     <= ~dl_out;
        end else if (dl_in != prev_in) begin
            prev_in <= dl_in;
            pend    <= line_en;
            cnt_rem <= dly_cycles - 1;
        end else if (pend) begin
            if (cnt_rem <= 1) begin
                dl_out <= ~dl_out;
                pend   <= 1'b0;
            end else begin
                cnt_rem <= cnt_rem - 1;
            end
        end
    end

    int   last_g;
    logic exp_dl_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
        for (int i = 1; i <= int'(NREQ); i++) begin
            if (r[(last + i) % NREQ]) return (last + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic check_reset_outputs();
        check("rst_ack", ack, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_dl_inR", dl_in, 0);
        check("rst_lat_cnt", lat_cnt, 0);
        check("rst_lat_valid", lat_valid, 0);
        check("rst_err", err, 0);
    endtask

    // One transaction from IDLE; req must already be nonzero. Returns the DUT's grant id.
    task automatic run_txn(input int dly, input bit early, output int g_obs);
        int exp_g;
        int k;
        bit got;
        dly_cycles = dly;
        line_en    = 1'b1;
        exp_g      = rr_pick(req, last_g);
        tick();
        exp_dl_in = ~exp_dl_in;
        g_obs     = int'(grant_id);
        check("launch_busy", busy, 1);
        check("grant_id", grant_id, exp_g);
        check("dl_inR_launch", dl_in, exp_dl_in);
        check("ack_in_wait", ack, 0);
        if (early) req[exp_g] = 1'b0;
        got = 1'b0;
        k   = 0;
        while (!got && k < 400) begin
            tick();
            k++;
            if (lat_valid) got = 1'b1;
        end
        check("lat_valid_seen", got, 1);
        check("lat_edge", k, dly + SYNC + 1);
        check("lat_cnt", lat_cnt, dly + SYNC);
        check("ack_onehot", ack, 32'(1) << exp_g);
        check("dl_inR_hold", dl_in, exp_dl_in);
        check("err_low", err, 0);
        if (!early) begin
            tick();
            check("lat_valid_pulse", lat_valid, 0);
            check("ack_held", ack, 32'(1) << exp_g);
            req[exp_g] = 1'b0;
        end
        tick();
        check("ack_release", ack, 0);
        check("idle_busy", busy, 0);
        check("lat_valid_low", lat_valid, 0);
        last_g = exp_g;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int g;
        int rr_exp [5];
        bit bad;
        rr_exp = '{0, 1, 2, 3, 0};
        rst_n     = 1'b1;
        req       = '0;
        last_g    = NREQ - 1;
        exp_dl_in = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // All requesters held high, each re-raising right after its handshake.
        for (int i = 0; i < 5; i++) begin
            req = '1;
            run_txn(2 + i, 1'b0, g);
            check("rr_order", g, rr_exp[i]);
        end

        // Single request, 5-cycle line: latency 5 + SYNC.
        req = 4'b0100;
        run_txn(5, 1'b0, g);
        check("single_grant", g, 2);

        // Early release during WAIT.
        req = 4'b0010;
        run_txn(6, 1'b1, g);
        check("early_grant", g, 1);

        // Stray return edge while idle.
        req = '0;
        stray_cnt++;
        bad = 1'b0;
        repeat (8) begin
            tick();
            if (lat_valid || ack != 0 || busy) bad = 1'b1;
        end
        check("stray_ignored", bad, 0);
        check("stray_grant_kept", grant_id, last_g);

        // Reset in the middle of WAIT.
        req = 4'b1000;
        dly_cycles = 10;
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        req = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        last_g    = NREQ - 1;
        exp_dl_in = 1'b0;
        tick();
        req = 4'b0001;
        run_txn(3, 1'b0, g);
        check("post_reset_grant", g, 0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            req = req | NREQ'($urandom_range(0, 15));
            if (req == 0) req[$urandom_range(0, NREQ - 1)] = 1'b1;
            run_txn(int'($urandom_range(2, 12)), ($urandom_range(0, 3) == 0), g);
            if (req == 0) repeat ($urandom_range(0, 2)) tick();
        end

`ifdef DELAY_ARB_TIMEOUT_EN
        begin
            int exp_g;
            int k;
            bit lv_seen;
            req = 4'b0100;
            line_en = 1'b0;
            exp_g = rr_pick(req, last_g);
            tick();
            exp_dl_in = ~exp_dl_in;
            check("to_dl_inR", dl_in, exp_dl_in);
            k = 0;
            lv_seen = 1'b0;
            while (ack == 0 && k < 400) begin
                tick();
                k++;
                if (lat_valid) lv_seen = 1'b1;
            end
            check("to_edge", k, TIMEOUT + 1);
            check("to_err", err, 1);
            check("to_ack", ack, 32'(1) << exp_g);
            check("to_lat_cnt", lat_cnt, TIMEOUT);
            stray_cnt++;
            repeat (6) begin
                tick();
                if (lat_valid) lv_seen = 1'b1;
            end
            check("to_no_lat_valid", lv_seen, 0);
            check("to_ack_held", ack, 32'(1) << exp_g);
            check("to_err_held", err, 1);
            req = '0;
            tick();
            check("to_ack_release", ack, 0);
            check("to_err_clear", err, 0);
            check("to_idle", busy, 0);
            last_g  = exp_g;
            line_en = 1'b1;
            req = 4'b1111;
            run_txn(4, 1'b0, g);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
